// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared constants, screen limits and state encoding for the pong engine
package pong_pkg;

   localparam logic [9:0] PADDLE_H     = 10'd64;
   localparam logic [9:0] PADDLE_W     = 10'd8;
   localparam logic [9:0] BALL_SZ      = 10'd8;
   localparam logic [9:0] PADDLE_SPEED = 10'd4;
   localparam logic [9:0] BALL_SPEED   = 10'd2;
   localparam logic [3:0] WIN_SCORE    = 4'd9;
   localparam logic [5:0] SERVE_FRAMES = 6'd60;

   localparam logic [9:0] PL_X         = 10'd16;
   localparam logic [9:0] PR_X         = 10'd616;
   localparam logic [9:0] PADDLE_Y_MAX = 10'd416;
   localparam logic [9:0] PADDLE_Y0    = 10'd208;
   localparam logic [9:0] BALL_X_MAX   = 10'd632;
   localparam logic [9:0] BALL_Y_MAX   = 10'd472;
   localparam logic [9:0] BALL_X0      = 10'd316;
   localparam logic [9:0] BALL_Y0      = 10'd236;
   localparam logic [9:0] HIT_L_X      = 10'd24;
   localparam logic [9:0] HIT_R_X      = 10'd608;
   localparam logic [9:0] CENTER_X0    = 10'd318;
   localparam logic [9:0] CENTER_X1    = 10'd321;

   typedef enum logic [1:0] {
      ST_SERVE     = 2'd0,
      ST_PLAY      = 2'd1,
      ST_POINT     = 2'd2,
      ST_GAME_OVER = 2'd3
   } state_t;

   // v lies in [lo, lo+len); widened so lo+len never wraps
   function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo, input logic [9:0] len);
      return ({1'b0, v} >= {1'b0, lo}) && ({1'b0, v} < ({1'b0, lo} + {1'b0, len}));
   endfunction

endpackage

// File: rtl/pong_paddle.sv
// rtl/pong_paddle.sv - one paddle: per-tick up/down step clamped to the playfield
module pong_paddle
   import pong_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       tick,
   input  logic       enable,
   input  logic       up,
   input  logic       dn,
   output logic [9:0] y
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         y <= PADDLE_Y0;
      end else if (tick && enable && (up ^ dn)) begin
         if (up)
            y <= (y < PADDLE_SPEED) ? 10'd0 : y - PADDLE_SPEED;
         else
            y <= (y > PADDLE_Y_MAX - PADDLE_SPEED) ? PADDLE_Y_MAX : y + PADDLE_SPEED;
      end
   end

endmodule

// File: rtl/pong_engine.sv
// rtl/pong_engine.sv - pong game state machine, ball physics, scoring and pixel render
module pong_engine
   import pong_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   input  logic       hsync,
   input  logic       vsync,
   input  logic       btn_l_up,
   input  logic       btn_l_dn,
   input  logic       btn_r_up,
   input  logic       btn_r_dn,
   output logic       r,
   output logic       g,
   output logic       b,
   output logic [3:0] score_l,
   output logic [3:0] score_r,
   output logic       game_over
);

   logic       vs_prev, tick;
   state_t     state;
   logic [5:0] serve_cnt;
   logic [9:0] ball_x, ball_y, pl_y, pr_y;
   logic       dir_x, dir_y, scorer_left;
   logic       paddles_live, overlap_l, overlap_r;
   logic       hit_l, hit_r, miss_l, miss_r, wall_top, wall_bot, white;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vs_prev <= 1'b1;
         tick    <= 1'b0;
      end else begin
         vs_prev <= vsync;
         tick    <= vs_prev & ~vsync;
      end
   end

   assign paddles_live = (state == ST_SERVE) || (state == ST_PLAY);

   pong_paddle u_pad_l (.clk(clk), .reset(reset), .tick(tick), .enable(paddles_live),
                        .up(btn_l_up), .dn(btn_l_dn), .y(pl_y));
   pong_paddle u_pad_r (.clk(clk), .reset(reset), .tick(tick), .enable(paddles_live),
                        .up(btn_r_up), .dn(btn_r_dn), .y(pr_y));

   // Event tests are phrased on the current position so a move below zero never wraps
   assign overlap_l = (ball_y + BALL_SZ > pl_y) && (ball_y < pl_y + PADDLE_H);
   assign overlap_r = (ball_y + BALL_SZ > pr_y) && (ball_y < pr_y + PADDLE_H);
   assign hit_l     = !dir_x && (ball_x >= HIT_L_X) && (ball_x <= HIT_L_X + BALL_SPEED) && overlap_l;
   assign hit_r     =  dir_x && (ball_x <= HIT_R_X) && (ball_x >= HIT_R_X - BALL_SPEED) && overlap_r;
   assign miss_l    = !dir_x && (ball_x <= BALL_SPEED);
   assign miss_r    =  dir_x && (ball_x >= BALL_X_MAX - BALL_SPEED);
   assign wall_top  = !dir_y && (ball_y <= BALL_SPEED);
   assign wall_bot  =  dir_y && (ball_y >= BALL_Y_MAX - BALL_SPEED);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_SERVE;
         serve_cnt   <= 6'd0;
         ball_x      <= BALL_X0;
         ball_y      <= BALL_Y0;
         dir_x       <= 1'b1;
         dir_y       <= 1'b1;
         scorer_left <= 1'b0;
         score_l     <= 4'd0;
         score_r     <= 4'd0;
         game_over   <= 1'b0;
      end else if (tick) begin
         case (state)
            ST_SERVE: begin
               if (serve_cnt == SERVE_FRAMES - 6'd1) begin
                  state     <= ST_PLAY;
                  serve_cnt <= 6'd0;
               end else begin
                  serve_cnt <= serve_cnt + 6'd1;
               end
            end
            ST_PLAY: begin
               if (wall_top) begin
                  ball_y <= 10'd0;
                  dir_y  <= 1'b1;
               end else if (wall_bot) begin
                  ball_y <= BALL_Y_MAX;
                  dir_y  <= 1'b0;
               end else begin
                  ball_y <= dir_y ? ball_y + BALL_SPEED : ball_y - BALL_SPEED;
               end
               if (hit_l) begin
                  ball_x <= HIT_L_X;
                  dir_x  <= 1'b1;
               end else if (hit_r) begin
                  ball_x <= HIT_R_X;
                  dir_x  <= 1'b0;
               end else if (miss_l) begin
                  ball_x      <= 10'd0;
                  scorer_left <= 1'b0;
                  state       <= ST_POINT;
               end else if (miss_r) begin
                  ball_x      <= BALL_X_MAX;
                  scorer_left <= 1'b1;
                  state       <= ST_POINT;
               end else begin
                  ball_x <= dir_x ? ball_x + BALL_SPEED : ball_x - BALL_SPEED;
               end
            end
            ST_POINT: begin
               if (scorer_left) score_l <= score_l + 4'd1;
               else             score_r <= score_r + 4'd1;
               if ((scorer_left ? score_l : score_r) == WIN_SCORE - 4'd1) begin
                  state     <= ST_GAME_OVER;
                  game_over <= 1'b1;
               end else begin
                  state     <= ST_SERVE;
                  ball_x    <= BALL_X0;
                  ball_y    <= BALL_Y0;
                  dir_x     <= scorer_left;    // serve toward the player who lost the point
                  serve_cnt <= 6'd0;
               end
            end
            ST_GAME_OVER: begin
               if (btn_l_up && btn_r_up) begin
                  state     <= ST_SERVE;
                  score_l   <= 4'd0;
                  score_r   <= 4'd0;
                  ball_x    <= BALL_X0;
                  ball_y    <= BALL_Y0;
                  serve_cnt <= 6'd0;
                  game_over <= 1'b0;
               end
            end
            default: state <= ST_SERVE;
         endcase
      end
   end

   always_comb begin
      white = 1'b0;
      if (in_span(hcount, PL_X, PADDLE_W) && in_span(vcount, pl_y, PADDLE_H)) white = 1'b1;
      if (in_span(hcount, PR_X, PADDLE_W) && in_span(vcount, pr_y, PADDLE_H)) white = 1'b1;
      if ((state != ST_GAME_OVER) && in_span(hcount, ball_x, BALL_SZ) && in_span(vcount, ball_y, BALL_SZ))
         white = 1'b1;
      if ((hcount >= CENTER_X0) && (hcount <= CENTER_X1) && !vcount[4]) white = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r <= 1'b0;
         g <= 1'b0;
         b <= 1'b0;
      end else begin
         r <= white & hsync & vsync;
         g <= white & hsync & vsync;
         b <= white & hsync & vsync;
      end
   end

endmodule

// File: tb/tb_pong_engine.sv
// tb/tb_pong_engine.sv - directed self-checking bench for pong_engine
module tb_pong_engine;
   import pong_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [9:0] hcount = '0, vcount = '0;
   logic       hsync = 1'b0, vsync = 1'b1;
   logic       btn_l_up = 0, btn_l_dn = 0, btn_r_up = 0, btn_r_dn = 0;
   logic       r, g, b, game_over;
   logic [3:0] score_l, score_r;
   int         n_checks = 0;
   int         n_fail = 0;

   pong_engine dut (
      .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
      .btn_l_up(btn_l_up), .btn_l_dn(btn_l_dn), .btn_r_up(btn_r_up), .btn_r_dn(btn_r_dn),
      .r(r), .g(g), .b(b), .score_l(score_l), .score_r(score_r), .game_over(game_over)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Reset lands while a frame tick is pending, so the tick must be discarded
   task automatic do_reset();
      @(negedge clk) vsync = 1'b0;
      @(negedge clk);
      reset = 1'b0; vsync = 1'b1; hsync = 1'b0;
      btn_l_up = 0; btn_l_dn = 0; btn_r_up = 0; btn_r_dn = 0;
      @(negedge clk);
      @(negedge clk) reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic frame();
      @(negedge clk) vsync = 1'b0;
      @(negedge clk) vsync = 1'b1;
      @(negedge clk);
   endtask

   task automatic pix(input string tag, input int x, input int y, input logic hs, input int exp);
      @(negedge clk);
      hcount = 10'(x); vcount = 10'(y); hsync = hs;
      @(negedge clk) check(tag, int'({r, g, b}), exp);
      hsync = 1'b0;
   endtask

   task automatic rally(input bit hit);
      do_reset();
      for (int t = 1; t <= (hit ? 498 : 511); t++) begin
         btn_l_up = (t <= 60);
         btn_r_up = (t <= 60);
         btn_r_dn = (t != 61);
         btn_l_dn = hit && (t >= 62) && (t <= 96);
         frame();
         if (t == 51) check("pl_y_t51", int'(dut.pl_y), 4);
         if (t == 52) check("pl_y_t52", int'(dut.pl_y), 0);
         if (t == 59) check("serve_t59", int'(dut.state), int'(ST_SERVE));
         if (t == 59) check("pr_y_hold", int'(dut.pr_y), 208);
         if (t == 60) check("play_t60", int'(dut.state), int'(ST_PLAY));
         if (t == 60) check("bx_t60", int'(dut.ball_x), 316);
         if (t == 60) check("pl_y_t60", int'(dut.pl_y), 0);
         if (t == 61) check("bx_t61", int'(dut.ball_x), 318);
         if (t == 61) check("by_t61", int'(dut.ball_y), 238);
         if (hit && t == 96) check("pl_y_t96", int'(dut.pl_y), 140);
         if (t == 113) check("pr_y_t113", int'(dut.pr_y), 416);
         if (t == 120) check("pr_y_clamp", int'(dut.pr_y), 416);
         if (t == 205) check("bx_t205", int'(dut.ball_x), 606);
         if (t == 205) check("by_t205", int'(dut.ball_y), 418);
         if (t == 206) check("bx_rhit", int'(dut.ball_x), 608);
         if (t == 206) check("by_rhit", int'(dut.ball_y), 416);
         if (t == 206) check("dx_rhit", int'(dut.dir_x), 0);
         if (t == 414) check("by_wall", int'(dut.ball_y), 0);
         if (t == 414) check("dy_wall", int'(dut.dir_y), 1);
         if (t == 497) check("bx_t497", int'(dut.ball_x), 26);
         if (t == 497) check("by_t497", int'(dut.ball_y), 166);
         if (hit && t == 498) begin
            check("bx_lhit", int'(dut.ball_x), 24);
            check("dx_lhit", int'(dut.dir_x), 1);
            check("by_lhit", int'(dut.ball_y), 168);
            check("score_l_hit", int'(score_l), 0);
            check("score_r_hit", int'(score_r), 0);
         end
         if (!hit && t == 498) check("dx_nohit", int'(dut.dir_x), 0);
         if (!hit && t == 509) check("bx_t509", int'(dut.ball_x), 2);
         if (!hit && t == 510) check("point_t510", int'(dut.state), int'(ST_POINT));
         if (!hit && t == 510) check("score_r_t510", int'(score_r), 0);
         if (!hit && t == 511) begin
            check("score_r_miss", int'(score_r), 1);
            check("serve_miss", int'(dut.state), int'(ST_SERVE));
            check("bx_serve", int'(dut.ball_x), 316);
            check("by_serve", int'(dut.ball_y), 236);
            check("dx_serve", int'(dut.dir_x), 0);
            check("dy_serve", int'(dut.dir_y), 1);
            check("cnt_serve", int'(dut.serve_cnt), 0);
         end
      end
      btn_l_up = 0; btn_l_dn = 0; btn_r_up = 0; btn_r_dn = 0;
   endtask

   initial begin
      do_reset();
      check("rst_state", int'(dut.state), int'(ST_SERVE));
      check("rst_cnt", int'(dut.serve_cnt), 0);
      check("rst_tick", int'(dut.tick), 0);
      check("rst_pl_y", int'(dut.pl_y), 208);
      check("rst_pr_y", int'(dut.pr_y), 208);
      check("rst_bx", int'(dut.ball_x), 316);
      check("rst_by", int'(dut.ball_y), 236);
      check("rst_dir", int'({dut.dir_x, dut.dir_y}), 3);
      check("rst_scores", int'({score_l, score_r}), 0);
      check("rst_game_over", int'(game_over), 0);
      check("rst_rgb", int'({r, g, b}), 0);

      // Registered render: old value right after the input change, new one a cycle later
      @(negedge clk);
      hcount = 10'd20; vcount = 10'd218; hsync = 1'b1;
      #1 check("rgb_latency0", int'({r, g, b}), 0);
      @(negedge clk) check("rgb_pl_paddle", int'({r, g, b}), 7);
      pix("rgb_hsync_low", 20, 218, 1'b0, 0);
      pix("rgb_black", 100, 100, 1'b1, 0);
      pix("rgb_center_on", 319, 0, 1'b1, 7);
      pix("rgb_center_gap", 319, 16, 1'b1, 0);
      pix("rgb_ball", 322, 240, 1'b1, 7);
      pix("rgb_pr_bottom", 620, 271, 1'b1, 7);
      pix("rgb_pr_below", 620, 272, 1'b1, 0);

      rally(1'b1);
      rally(1'b0);

      // Nine unreturned serves to the right player; each point takes 219 ticks
      do_reset();
      repeat (8 * 219) frame();
      check("score_l_8", int'(score_l), 8);
      check("score_r_0", int'(score_r), 0);
      check("serve_after_8", int'(dut.state), int'(ST_SERVE));
      repeat (218) frame();
      check("point_9", int'(dut.state), int'(ST_POINT));
      check("bx_miss_r", int'(dut.ball_x), 632);
      check("by_miss_r", int'(dut.ball_y), 392);
      pix("rgb_ball_point", 634, 394, 1'b1, 7);
      frame();
      check("score_l_9", int'(score_l), 9);
      check("game_over_1", int'(game_over), 1);
      check("state_go", int'(dut.state), int'(ST_GAME_OVER));
      pix("rgb_ball_hidden", 634, 394, 1'b1, 0);

      @(negedge clk);
      hcount = 10'd319; vcount = 10'd0; hsync = 1'b1; btn_l_up = 1'b1; vsync = 1'b0;
      @(negedge clk) check("rgb_vblank", int'({r, g, b}), 0);
      vsync = 1'b1;
      @(negedge clk) check("rgb_vactive", int'({r, g, b}), 7);
      @(negedge clk) check("go_one_button", int'(dut.state), int'(ST_GAME_OVER));
      hsync = 1'b0;
      btn_r_up = 1'b1;
      frame();
      check("restart_state", int'(dut.state), int'(ST_SERVE));
      check("restart_scores", int'({score_l, score_r}), 0);
      check("restart_go", int'(game_over), 0);
      check("restart_bx", int'(dut.ball_x), 316);
      check("restart_by", int'(dut.ball_y), 236);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
